// File: rtl/sram_phase_ctrl_pkg.sv
// rtl/sram_phase_ctrl_pkg.sv - shared types and default timing for the SRAM phase sequencer
package sram_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WL,
    SENSE,
    RESP
  } state_t;

  localparam int T_PRE_DEF   = 2;
  localparam int T_WL_DEF    = 1;
  localparam int T_SENSE_DEF = 2;

  // Longest phase sets the width of the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_wl_decoder.sv
// rtl/sram_wl_decoder.sv - registered one-hot wordline decoder
module sram_wl_decoder #(
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   en,
  output logic [2**ADDR_W-1:0]   wl
);

  // Wordlines come straight from flops so the array never sees decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wl <= '0;
    end else begin
      wl <= '0;
      if (en) wl[addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/sram_phase_ctrl.sv
// rtl/sram_phase_ctrl.sv - request sequencer driving precharge/wordline/write/sense phases
module sram_phase_ctrl
  import sram_phase_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int T_PRE   = T_PRE_DEF,
  parameter int T_WL    = T_WL_DEF,
  parameter int T_SENSE = T_SENSE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  mem_pre,
  output logic [2**ADDR_W-1:0]  mem_wl,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_din,
  output logic                  mem_sae,
  input  logic [DATA_W-1:0]     mem_dout
);

  localparam int CNT_W = $clog2(max3(T_PRE, T_WL, T_SENSE) + 1);
  localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(T_PRE - 1);
  localparam logic [CNT_W-1:0] WL_LD    = CNT_W'(T_WL - 1);
  localparam logic [CNT_W-1:0] SENSE_LD = CNT_W'(T_SENSE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt, next_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              wl_en;

  assign accept = (state == IDLE) && req_valid && req_ready;
  assign wl_en  = (next_state == WL) || (next_state == SENSE);

  // State and phase counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Phase sequencing: each phase loads its length-1 and ends when the counter hits 0.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = PRE;
          next_cnt   = PRE_LD;
        end
      end
      PRE: begin
        if (cnt == '0) begin
          next_state = WL;
          next_cnt   = WL_LD;
        end else begin
          next_cnt = cnt - CNT_ONE;
        end
      end
      WL: begin
        if (cnt == '0) begin
          if (we_q) begin
            next_state = RESP;
          end else begin
            next_state = SENSE;
            next_cnt   = SENSE_LD;
          end
        end else begin
          next_cnt = cnt - CNT_ONE;
        end
      end
      SENSE: begin
        if (cnt == '0) next_state = RESP;
        else           next_cnt   = cnt - CNT_ONE;
      end
      RESP: begin
        if (resp_valid && resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the request on accept; later req_* changes cannot reach the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      we_q    <= req_we;
      wdata_q <= req_wdata;
    end
  end

  // Controls are registered decodes of the next state, so they line up with the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_pre    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_din    <= '0;
      mem_sae    <= 1'b0;
    end else begin
      req_ready  <= (next_state == IDLE);
      resp_valid <= (next_state == RESP);
      mem_pre    <= (next_state == PRE);
      mem_wen    <= (next_state == WL) && we_q;
      mem_din    <= ((next_state == WL) && we_q) ? wdata_q : '0;
      mem_sae    <= (next_state == SENSE);
      if ((state == SENSE) && (cnt == '0)) resp_rdata <= mem_dout;
    end
  end

  sram_wl_decoder #(
    .ADDR_W (ADDR_W)
  ) u_wl_decoder (
    .clk  (clk),
    .rst  (rst),
    .addr (addr_q),
    .en   (wl_en),
    .wl   (mem_wl)
  );

endmodule

// File: tb/tb_sram_phase_ctrl.sv
// tb/tb_sram_phase_ctrl.sv - self-checking bench for sram_phase_ctrl
module tb_sram_phase_ctrl;

  localparam int TP = 2;
  localparam int TW = 1;
  localparam int TS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = 4'd0;
  logic [7:0]  req_wdata = 8'd0;
  logic        resp_ready = 1'b0;
  logic        sel2 = 1'b0;

  logic        req_ready1, resp_valid1, mem_pre1, mem_wen1, mem_sae1;
  logic [7:0]  resp_rdata1, mem_din1, mem_dout1;
  logic [15:0] mem_wl1;
  logic        req_ready2, resp_valid2, mem_pre2, mem_wen2, mem_sae2;
  logic [7:0]  resp_rdata2, mem_din2, mem_dout2;
  logic [15:0] mem_wl2;

  logic        v1, v2, rr1, rr2;
  logic        c_ready, c_rv, c_pre, c_wen, c_sae;
  logic [7:0]  c_rdata;
  logic [15:0] c_wl;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  assign v1  = req_valid & ~sel2;
  assign v2  = req_valid & sel2;
  assign rr1 = resp_ready & ~sel2;
  assign rr2 = resp_ready & sel2;

  assign c_ready = sel2 ? req_ready2  : req_ready1;
  assign c_rv    = sel2 ? resp_valid2 : resp_valid1;
  assign c_rdata = sel2 ? resp_rdata2 : resp_rdata1;
  assign c_pre   = sel2 ? mem_pre2    : mem_pre1;
  assign c_wen   = sel2 ? mem_wen2    : mem_wen1;
  assign c_sae   = sel2 ? mem_sae2    : mem_sae1;
  assign c_wl    = sel2 ? mem_wl2     : mem_wl1;

  sram_phase_ctrl #(.ADDR_W(4), .DATA_W(8), .T_PRE(TP), .T_WL(TW), .T_SENSE(TS)) dut (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(req_ready1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid1), .resp_ready(rr1),
    .resp_rdata(resp_rdata1), .mem_pre(mem_pre1), .mem_wl(mem_wl1), .mem_wen(mem_wen1),
    .mem_din(mem_din1), .mem_sae(mem_sae1), .mem_dout(mem_dout1)
  );

  sram_phase_ctrl #(.ADDR_W(4), .DATA_W(8), .T_PRE(1), .T_WL(3), .T_SENSE(1)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(req_ready2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid2), .resp_ready(rr2),
    .resp_rdata(resp_rdata2), .mem_pre(mem_pre2), .mem_wl(mem_wl2), .mem_wen(mem_wen2),
    .mem_din(mem_din2), .mem_sae(mem_sae2), .mem_dout(mem_dout2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [15:0] w);
    for (int i = 0; i < 16; i++) if (w[i]) return i;
    return 0;
  endfunction

  // Behavioural bitcell arrays: sense amps show the selected word while enabled.
  logic [7:0] arr1 [16];
  logic [7:0] arr2 [16];
  assign mem_dout1 = mem_sae1 ? arr1[oh_idx(mem_wl1)] : 8'h00;
  assign mem_dout2 = mem_sae2 ? arr2[oh_idx(mem_wl2)] : 8'h00;

  // Array writes happen while the write driver and a wordline are both on.
  always @(posedge clk) begin
    if (mem_wen1) arr1[oh_idx(mem_wl1)] <= mem_din1;
    if (mem_wen2) arr2[oh_idx(mem_wl2)] <= mem_din2;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model of dut: outputs as a function of cycles since accept.
  int         busy = 0, k = 0, pend = 1;
  logic       t_we = 1'b0;
  int         t_addr = 0;
  logic [7:0] t_wd = 8'h00;
  logic [7:0] exp_rdata = 8'h00;
  logic [7:0] mm [16];

  always @(negedge clk) begin
    int lat;
    logic e_pre, e_wen, e_sae, e_rv, e_rdy;
    logic [15:0] e_wl;
    if (rst) begin
      busy = 0; k = 0; pend = 1; exp_rdata = 8'h00;
      chk("m_rst_ready", 32'(req_ready1), 32'd0);
      chk("m_rst_ctrl", {mem_wl1, mem_din1, 5'd0, mem_pre1, mem_wen1, mem_sae1}, 32'd0);
      chk("m_rst_resp", {23'd0, resp_valid1, resp_rdata1}, 32'd0);
    end else begin
      if (busy != 0) k++;
      lat   = t_we ? (TP + TW + 1) : (TP + TW + TS + 1);
      e_pre = (busy != 0) && k >= 1 && k <= TP;
      e_wl  = ((busy != 0) && k > TP && k <= TP + TW + (t_we ? 0 : TS)) ? (16'd1 << t_addr) : 16'd0;
      e_wen = (busy != 0) && t_we && k > TP && k <= TP + TW;
      e_sae = (busy != 0) && !t_we && k > TP + TW && k <= TP + TW + TS;
      e_rv  = (busy != 0) && k >= lat;
      e_rdy = (busy == 0) && (pend == 0);
      if ((busy != 0) && !t_we && k == lat) exp_rdata = mm[t_addr];
      chk("m_pre", 32'(mem_pre1), 32'(e_pre));
      chk("m_wl", 32'(mem_wl1), 32'(e_wl));
      chk("m_wen", 32'(mem_wen1), 32'(e_wen));
      chk("m_din", 32'(mem_din1), e_wen ? 32'(t_wd) : 32'd0);
      chk("m_sae", 32'(mem_sae1), 32'(e_sae));
      chk("m_resp_valid", 32'(resp_valid1), 32'(e_rv));
      chk("m_resp_rdata", 32'(resp_rdata1), 32'(exp_rdata));
      chk("m_req_ready", 32'(req_ready1), 32'(e_rdy));
      pend = 0;
      if (e_rv && rr1) begin
        busy = 0; k = 0;
      end else if (e_rdy && v1) begin
        busy = 1; k = 0; t_we = req_we; t_addr = int'(req_addr); t_wd = req_wdata;
        if (req_we) mm[req_addr] = req_wdata;
      end
    end
  end

  // Phase monitor on whichever instance is selected.
  int pre_n, wl_n, sae_n, wen_n, ovl;
  logic first_sae;
  logic [15:0] wl_last, prev_wl;
  logic [15:0] wl_seq [$];
  int acc_q [$];
  int hs_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (c_pre) pre_n++;
      if (c_wen) wen_n++;
      if (c_sae) sae_n++;
      if (c_wl != 16'd0) begin
        wl_n++;
        wl_last = c_wl;
        if (prev_wl == 16'd0) first_sae = c_sae;
        if (c_wl != prev_wl) wl_seq.push_back(c_wl);
      end
      if ((c_pre && c_wl != 16'd0) || (c_wen && c_sae)) ovl++;
      if (req_valid && c_ready) acc_q.push_back(cyc + 1);
      if (c_rv && resp_ready) hs_q.push_back(cyc + 1);
    end
    prev_wl = c_wl;
  end

  task automatic clr_mon();
    pre_n = 0; wl_n = 0; sae_n = 0; wen_n = 0; ovl = 0;
    first_sae = 1'bx; wl_last = 16'd0;
    wl_seq.delete(); acc_q.delete(); hs_q.delete();
  endtask

  // One request/response; stall = cycles resp_ready is held low once resp_valid is up.
  task automatic xfer(input logic we, input logic [3:0] a, input logic [7:0] d,
                      input int stall, output int lat);
    int n;
    logic [7:0] held;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; resp_ready = 1'b0;
    n = 0;
    while (!c_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("accept_bound", 32'(c_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~d;
    lat = 1;
    while (!c_rv && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("resp_bound", 32'(c_rv), 32'd1);
    held = c_rdata;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(c_rv), 32'd1);
      chk("stall_rdata", 32'(c_rdata), 32'(held));
      chk("stall_ready", 32'(c_ready), 32'd0);
      chk("stall_ctrl", {c_wl, 13'd0, c_pre, c_wen, c_sae}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    int lat, n;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_low", 32'(req_ready1), 32'd0);
    chk("rst_rdata", 32'(resp_rdata1), 32'd0);
    rst = 1'b0;
    chk("rel_ready_same", 32'(req_ready1), 32'd0);
    @(posedge clk); #1;
    chk("rel_ready_next", 32'(req_ready1), 32'd1);

    // Write then read addr 5.
    clr_mon();
    xfer(1'b1, 4'd5, 8'hA5, 0, lat);
    chk("wr_latency", 32'(lat), 32'd4);
    chk("wr_wen_cycles", 32'(wen_n), 32'd1);
    xfer(1'b0, 4'd5, 8'h00, 0, lat);
    chk("rd_latency", 32'(lat), 32'd6);
    chk("rd_data", 32'(c_rdata), 32'hA5);

    // Response back-pressure.
    xfer(1'b0, 4'd5, 8'h00, 10, lat);
    chk("stall_rd_data", 32'(c_rdata), 32'hA5);

    // Phase trace on a read of addr 3.
    xfer(1'b1, 4'd3, 8'h5A, 0, lat);
    clr_mon();
    xfer(1'b0, 4'd3, 8'h00, 0, lat);
    chk("tr_pre_cycles", 32'(pre_n), 32'd2);
    chk("tr_wl_cycles", 32'(wl_n), 32'd3);
    chk("tr_wl_value", 32'(wl_last), 32'h0008);
    chk("tr_sae_cycles", 32'(sae_n), 32'd2);
    chk("tr_sae_first_wl", 32'(first_sae), 32'd0);
    chk("tr_overlap", 32'(ovl), 32'd0);
    chk("tr_rdata", 32'(c_rdata), 32'h5A);

    // Reset during SENSE.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
    n = 0;
    while (!c_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!mem_sae1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("rs_reach_sense", 32'(mem_sae1), 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_ctrl_zero", {mem_wl1, mem_din1, 5'd0, mem_pre1, mem_wen1, mem_sae1}, 32'd0);
    chk("rs_resp_valid", 32'(resp_valid1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rs_ready_same", 32'(req_ready1), 32'd0);
    @(posedge clk); #1;
    chk("rs_ready_next", 32'(req_ready1), 32'd1);
    xfer(1'b0, 4'd5, 8'h00, 0, lat);
    chk("rs_next_latency", 32'(lat), 32'd6);
    chk("rs_next_rdata", 32'(c_rdata), 32'hA5);

    // Back-to-back writes to 0 then 15 with req_valid held.
    clr_mon();
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd0; req_wdata = 8'h11;
    n = 0;
    while (acc_q.size() < 1 && n < 20) begin @(posedge clk); #1; n++; end
    req_addr = 4'd15; req_wdata = 8'hEE;
    n = 0;
    while (acc_q.size() < 2 && n < 30) begin @(posedge clk); #1; n++; end
    req_valid = 1'b0;
    n = 0;
    while (hs_q.size() < 2 && n < 30) begin @(posedge clk); #1; n++; end
    resp_ready = 1'b0;
    chk("b2b_accepts", 32'(acc_q.size()), 32'd2);
    chk("b2b_handshakes", 32'(hs_q.size()), 32'd2);
    chk("b2b_wl_count", 32'(wl_seq.size()), 32'd2);
    if (acc_q.size() == 2 && hs_q.size() == 2 && wl_seq.size() == 2) begin
      chk("b2b_first_lat", 32'(hs_q[0] - acc_q[0]), 32'd4);
      chk("b2b_second_after_hs", 32'(acc_q[1] - hs_q[0]), 32'd1);
      chk("b2b_wl0", 32'(wl_seq[0]), 32'h0001);
      chk("b2b_wl1", 32'(wl_seq[1]), 32'h8000);
    end
    xfer(1'b0, 4'd0, 8'h00, 0, lat);
    chk("b2b_rd0", 32'(c_rdata), 32'h11);
    xfer(1'b0, 4'd15, 8'h00, 0, lat);
    chk("b2b_rd15", 32'(c_rdata), 32'hEE);

    // Timing sweep on the T_PRE=1, T_WL=3, T_SENSE=1 instance.
    @(posedge clk); #1;
    sel2 = 1'b1;
    clr_mon();
    xfer(1'b1, 4'd9, 8'h3C, 0, lat);
    chk("sw_wr_latency", 32'(lat), 32'd5);
    chk("sw_wr_pre", 32'(pre_n), 32'd1);
    chk("sw_wr_wl", 32'(wl_n), 32'd3);
    chk("sw_wr_wen", 32'(wen_n), 32'd3);
    chk("sw_wr_sae", 32'(sae_n), 32'd0);
    clr_mon();
    xfer(1'b0, 4'd9, 8'h00, 0, lat);
    chk("sw_rd_latency", 32'(lat), 32'd6);
    chk("sw_rd_pre", 32'(pre_n), 32'd1);
    chk("sw_rd_wl", 32'(wl_n), 32'd4);
    chk("sw_rd_sae", 32'(sae_n), 32'd1);
    chk("sw_rd_wl_value", 32'(wl_last), 32'h0200);
    chk("sw_rd_data", 32'(c_rdata), 32'h3C);
    chk("sw_overlap", 32'(ovl), 32'd0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
